ts_packet_mux: RTL and testbench



---
 rtl/ts_packet_mux.sv | 200 ++++++++++++++++++++
 tb/tb_ts_packet_mux.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_packet_mux.sv
// ts_packet_mux
//   Merges NUM_CH tuner packet FIFOs into one byte stream. For each packet it
//   picks a ready, enabled channel with a round-robin scan. It then emits
//   HDR_BYTES header bytes fetched from an external per-channel header file,
//   followed by PKT_BYTES payload bytes read from that channel's show-ahead
//   FIFO. When nothing has been ready for IDLE_TIMEOUT scan cycles, a null
//   packet is stuffed instead. All stream outputs are registered, so a byte
//   read or addressed in cycle t appears on the outputs in cycle t+1.
//
// Ports
//   SYS_CLK          single clock, rising edge
//   RST              asynchronous, active-low reset
//   CH_ENABLE        per-channel enable mask
//   GOT_FULL_PACKET  per-channel "FIFO holds a whole packet" flag
//   DATA_IN_BUS      show-ahead FIFO data, channel i at [8i+7:8i]
//   RD_REQ           per-channel FIFO read strobe
//   HDR_ADDR         header file address (ch*HDR_BYTES + idx)
//   HDR_BYTE         header file data, valid in the same cycle as HDR_ADDR
//   DATA_OUT         output byte
//   D_VALID_OUT      DATA_OUT valid
//   P_SYNC_OUT       marks payload byte 0 of every packet
//   CH_ID_OUT        source channel of the current packet (0 for null packets)
//   NULL_OUT         marks every byte of a stuffed null packet
//   SYNC_ERR         pulse with payload byte 0 of a real packet that is not 8'h47
module ts_packet_mux #(
    parameter int NUM_CH       = 4,
    parameter int HDR_BYTES    = 4,
    parameter int PKT_BYTES    = 188,
    parameter int IDLE_TIMEOUT = 256,
    localparam int CH_W = $clog2(NUM_CH),
    localparam int HA_W = (NUM_CH * HDR_BYTES > 1) ? $clog2(NUM_CH * HDR_BYTES) : 1
) (
    input  logic                  SYS_CLK,
    input  logic                  RST,
    input  logic [NUM_CH-1:0]     CH_ENABLE,
    input  logic [NUM_CH-1:0]     GOT_FULL_PACKET,
    input  logic [8*NUM_CH-1:0]   DATA_IN_BUS,
    output logic [NUM_CH-1:0]     RD_REQ,
    output logic [HA_W-1:0]       HDR_ADDR,
    input  logic [7:0]            HDR_BYTE,
    output logic [7:0]            DATA_OUT,
    output logic                  D_VALID_OUT,
    output logic                  P_SYNC_OUT,
    output logic [CH_W-1:0]       CH_ID_OUT,
    output logic                  NULL_OUT,
    output logic                  SYNC_ERR
);

    localparam logic [1:0] S_SCAN    = 2'd0;
    localparam logic [1:0] S_HEADER  = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;

    localparam int IC_W = $clog2(IDLE_TIMEOUT + 2);
    localparam logic [IC_W-1:0] IDLE_LAST = IC_W'((IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1);
    localparam logic [7:0] HDR_LAST = 8'((HDR_BYTES == 0) ? 0 : HDR_BYTES - 1);
    localparam logic [7:0] PKT_LAST = 8'(PKT_BYTES - 1);
    localparam logic [1:0] FIRST_STATE = (HDR_BYTES == 0) ? S_PAYLOAD : S_HEADER;

    logic [1:0]        state;
    logic [CH_W-1:0]   sel;
    logic [CH_W-1:0]   rr_ptr;
    logic [7:0]        byte_cnt;
    logic [IC_W-1:0]   idle_cnt;
    logic              null_pkt;

    logic [NUM_CH-1:0] cand;
    logic [CH_W-1:0]   pick;
    logic [CH_W-1:0]   idx;
    logic              found;
    logic [7:0]        sel_data;
    logic [7:0]        null_byte;

    assign cand     = GOT_FULL_PACKET & CH_ENABLE;
    assign sel_data = DATA_IN_BUS[{sel, 3'b000} +: 8];

    // Round-robin pick: first candidate after rr_ptr, wrapping, so the
    // channel served last has the lowest priority on the next scan.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!found && cand[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Null packet payload: fixed PID 0x1FFF header followed by 0xFF stuffing.
    always_comb begin
        case (byte_cnt)
            8'd0:    null_byte = 8'h47;
            8'd1:    null_byte = 8'h1F;
            8'd2:    null_byte = 8'hFF;
            8'd3:    null_byte = 8'h10;
            default: null_byte = 8'hFF;
        endcase
    end

    // Header address and FIFO strobe come straight from the state, so the
    // header file / FIFO respond in the same cycle and the output register
    // captures the byte at the following edge.
    always_comb begin
        RD_REQ   = '0;
        HDR_ADDR = '0;
        if (state == S_HEADER) begin
            HDR_ADDR = HA_W'(int'(sel) * HDR_BYTES + int'(byte_cnt));
        end
        if (state == S_PAYLOAD && !null_pkt) begin
            RD_REQ[sel] = 1'b1;
        end
    end

    // Packet sequencing. A ready channel is tested before the idle timeout,
    // so a channel that becomes ready on the timeout cycle wins.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_SCAN;
            sel      <= '0;
            rr_ptr   <= CH_W'(NUM_CH - 1);
            byte_cnt <= '0;
            idle_cnt <= '0;
            null_pkt <= 1'b0;
        end else begin
            case (state)
                S_SCAN: begin
                    byte_cnt <= '0;
                    if (|cand) begin
                        sel      <= pick;
                        rr_ptr   <= pick;
                        idle_cnt <= '0;
                        null_pkt <= 1'b0;
                        state    <= FIRST_STATE;
                    end else if (IDLE_TIMEOUT != 0) begin
                        if (idle_cnt == IDLE_LAST) begin
                            idle_cnt <= '0;
                            null_pkt <= 1'b1;
                            state    <= FIRST_STATE;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                S_HEADER: begin
                    if (byte_cnt == HDR_LAST) begin
                        byte_cnt <= '0;
                        state    <= S_PAYLOAD;
                    end else begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                S_PAYLOAD: begin
                    if (byte_cnt == PKT_LAST) begin
                        byte_cnt <= '0;
                        state    <= S_SCAN;
                    end else begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                default: state <= S_SCAN;
            endcase
        end
    end

    // Registered output stage. SCAN always produces an invalid cycle, which
    // guarantees a gap between consecutive packets.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            DATA_OUT    <= '0;
            D_VALID_OUT <= 1'b0;
            P_SYNC_OUT  <= 1'b0;
            CH_ID_OUT   <= '0;
            NULL_OUT    <= 1'b0;
            SYNC_ERR    <= 1'b0;
        end else begin
            DATA_OUT    <= '0;
            D_VALID_OUT <= 1'b0;
            P_SYNC_OUT  <= 1'b0;
            CH_ID_OUT   <= '0;
            NULL_OUT    <= 1'b0;
            SYNC_ERR    <= 1'b0;
            if (state == S_HEADER) begin
                DATA_OUT    <= null_pkt ? 8'h00 : HDR_BYTE;
                D_VALID_OUT <= 1'b1;
                CH_ID_OUT   <= null_pkt ? '0 : sel;
                NULL_OUT    <= null_pkt;
            end else if (state == S_PAYLOAD) begin
                DATA_OUT    <= null_pkt ? null_byte : sel_data;
                D_VALID_OUT <= 1'b1;
                P_SYNC_OUT  <= (byte_cnt == 8'd0);
                CH_ID_OUT   <= null_pkt ? '0 : sel;
                NULL_OUT    <= null_pkt;
                SYNC_ERR    <= !null_pkt && (byte_cnt == 8'd0) && (sel_data != 8'h47);
            end
        end
    end

endmodule

// File: tb/tb_ts_packet_mux.sv
// tb_ts_packet_mux
//   Drives ts_packet_mux (4 channels, 4 header bytes, 188 payload bytes,
//   idle timeout 16) from modelled show-ahead FIFOs and a header file.
//   Expected output bytes are queued when packets are loaded and compared
//   as the DUT emits them.
module tb_ts_packet_mux;

    localparam int NUM_CH       = 4;
    localparam int HDR_BYTES    = 4;
    localparam int PKT_BYTES    = 188;
    localparam int IDLE_TIMEOUT = 16;
    localparam int PKT_LEN      = HDR_BYTES + PKT_BYTES;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [NUM_CH-1:0]   ch_enable = '1;
    logic [NUM_CH-1:0]   got_full = '0;
    logic [8*NUM_CH-1:0] data_in = '0;
    logic [NUM_CH-1:0]   rd_req;
    logic [3:0]          hdr_addr;
    logic [7:0]          hdr_byte;
    logic [7:0]          data_out;
    logic                d_valid;
    logic                p_sync;
    logic [1:0]          ch_id;
    logic                null_out;
    logic                sync_err;

    typedef struct {
        logic [7:0] data;
        logic       psync;
        logic       nul;
        logic       serr;
        logic [1:0] ch;
        logic       first;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] fifo[NUM_CH][$];
    logic [7:0] hdr_mem[16];
    int         rd_count[NUM_CH];
    logic [NUM_CH-1:0] rd_pend = '0;
    logic       prev_valid = 1'b0;
    int         checks = 0;
    int         passed = 0;
    int         byte_no = 0;

    always #5 clk = ~clk;

    assign hdr_byte = hdr_mem[hdr_addr];

    ts_packet_mux #(
        .NUM_CH(NUM_CH), .HDR_BYTES(HDR_BYTES),
        .PKT_BYTES(PKT_BYTES), .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .SYS_CLK(clk), .RST(rst_n), .CH_ENABLE(ch_enable),
        .GOT_FULL_PACKET(got_full), .DATA_IN_BUS(data_in), .RD_REQ(rd_req),
        .HDR_ADDR(hdr_addr), .HDR_BYTE(hdr_byte), .DATA_OUT(data_out),
        .D_VALID_OUT(d_valid), .P_SYNC_OUT(p_sync), .CH_ID_OUT(ch_id),
        .NULL_OUT(null_out), .SYNC_ERR(sync_err)
    );

    // FIFO model: bytes strobed during a cycle are consumed at its closing
    // edge (unless reset was low there); bus and full flags update just after.
    always @(posedge clk) begin
        logic [NUM_CH-1:0] pend;
        logic              rs;
        pend = rd_pend;
        rs   = rst_n;
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rs && pend[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
            data_in[8*i +: 8] = (fifo[i].size() > 0) ? fifo[i][0] : 8'h00;
            got_full[i]       = (fifo[i].size() >= PKT_BYTES);
        end
    end

    // Read-strobe capture and output scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        rd_pend = rd_req;
        for (int i = 0; i < NUM_CH; i++) rd_count[i] += int'(rd_req[i]);
        if (d_valid) begin
            checks++;
            byte_no++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL stream_extra: byte %0d got data=%h null=%b ch=%0d, required no valid byte",
                         byte_no, data_out, null_out, ch_id);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e.data || p_sync !== e.psync || null_out !== e.nul ||
                    sync_err !== e.serr || ch_id !== e.ch || prev_valid !== !e.first) begin
                    $display("[TB] FAIL stream_byte %0d: got data=%h psync=%b null=%b serr=%b ch=%0d prev_valid=%b, required data=%h psync=%b null=%b serr=%b ch=%0d prev_valid=%b",
                             byte_no, data_out, p_sync, null_out, sync_err, ch_id, prev_valid,
                             e.data, e.psync, e.nul, e.serr, e.ch, !e.first);
                end else begin
                    passed++;
                end
            end
        end
        prev_valid = d_valid;
    end

    task automatic load_fifo(input int ch, input int seed, input logic [7:0] sync);
        for (int k = 0; k < PKT_BYTES; k++)
            fifo[ch].push_back((k == 0) ? sync : 8'(seed + k));
    endtask

    task automatic expect_pkt(input int ch, input int seed, input logic [7:0] sync);
        exp_t x;
        for (int k = 0; k < HDR_BYTES; k++) begin
            x = '{data: hdr_mem[ch*HDR_BYTES + k], psync: 1'b0, nul: 1'b0, serr: 1'b0,
                  ch: 2'(ch), first: (k == 0)};
            exp_q.push_back(x);
        end
        for (int k = 0; k < PKT_BYTES; k++) begin
            x = '{data: (k == 0) ? sync : 8'(seed + k), psync: (k == 0), nul: 1'b0,
                  serr: (k == 0) && (sync != 8'h47), ch: 2'(ch), first: 1'b0};
            exp_q.push_back(x);
        end
    endtask

    task automatic expect_null();
        exp_t x;
        logic [7:0] b;
        for (int k = 0; k < PKT_LEN; k++) begin
            if (k < HDR_BYTES)           b = 8'h00;
            else if (k == HDR_BYTES)     b = 8'h47;
            else if (k == HDR_BYTES + 1) b = 8'h1F;
            else if (k == HDR_BYTES + 3) b = 8'h10;
            else                         b = 8'hFF;
            x = '{data: b, psync: (k == HDR_BYTES), nul: 1'b1, serr: 1'b0, ch: 2'd0, first: (k == 0)};
            exp_q.push_back(x);
        end
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ch_enable = '1;
        exp_q.delete();
        for (int i = 0; i < NUM_CH; i++) fifo[i].delete();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_out, d_valid, p_sync, ch_id, null_out, sync_err, rd_req} !== '0) begin
            $display("[TB] FAIL reset_outputs: got data=%h valid=%b psync=%b ch=%0d null=%b serr=%b rd=%b, required all 0",
                     data_out, d_valid, p_sync, ch_id, null_out, sync_err, rd_req);
        end else passed++;
    endtask

    task automatic test_single();
        int r0[NUM_CH];
        bit ok;
        enter_reset();
        load_fifo(2, 0, 8'h47);
        expect_pkt(2, 0, 8'h47);
        r0 = rd_count;
        release_reset();
        wait_drain(600, ok);
        checks++;
        if (!ok) $display("[TB] FAIL single_drain: got %0d bytes outstanding, required 0", exp_q.size());
        else passed++;
        for (int i = 0; i < NUM_CH; i++) begin
            checks++;
            if (rd_count[i] - r0[i] !== ((i == 2) ? PKT_BYTES : 0))
                $display("[TB] FAIL single_rd_req ch%0d: got %0d reads, required %0d",
                         i, rd_count[i] - r0[i], (i == 2) ? PKT_BYTES : 0);
            else passed++;
        end
    endtask

    task automatic test_fairness();
        bit ok;
        enter_reset();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < NUM_CH; c++) begin
                load_fifo(c, 16*c + 64*p, 8'h47);
                expect_pkt(c, 16*c + 64*p, 8'h47);
            end
        release_reset();
        wait_drain(2200, ok);
        checks++;
        if (!ok) $display("[TB] FAIL fairness_drain: got %0d bytes outstanding, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_masking();
        int r0[NUM_CH];
        bit ok;
        enter_reset();
        ch_enable = 4'b1011;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < NUM_CH; c++) begin
                load_fifo(c, 8*c + 100*p, 8'h47);
                if (c != 2) expect_pkt(c, 8*c + 100*p, 8'h47);
            end
        r0 = rd_count;
        release_reset();
        wait_drain(1700, ok);
        checks++;
        if (!ok) $display("[TB] FAIL masking_drain: got %0d bytes outstanding, required 0", exp_q.size());
        else passed++;
        checks++;
        if (rd_count[2] - r0[2] !== 0)
            $display("[TB] FAIL masking_rd_req2: got %0d reads, required 0", rd_count[2] - r0[2]);
        else passed++;
        checks++;
        if (rd_count[3] - r0[3] !== 2*PKT_BYTES)
            $display("[TB] FAIL masking_rd_req3: got %0d reads, required %0d", rd_count[3] - r0[3], 2*PKT_BYTES);
        else passed++;
    endtask

    task automatic test_stuffing();
        int r0[NUM_CH];
        int k;
        bit ok;
        enter_reset();
        expect_null();
        r0 = rd_count;
        release_reset();
        for (k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (d_valid) break;
        end
        checks++;
        if (k !== IDLE_TIMEOUT + 1)
            $display("[TB] FAIL stuffing_start: got first valid at edge %0d, required %0d", k, IDLE_TIMEOUT + 1);
        else passed++;
        wait_drain(300, ok);
        checks++;
        if (!ok) $display("[TB] FAIL stuffing_drain: got %0d bytes outstanding, required 0", exp_q.size());
        else passed++;
        checks++;
        if ((rd_count[0] + rd_count[1] + rd_count[2] + rd_count[3]) - (r0[0] + r0[1] + r0[2] + r0[3]) !== 0)
            $display("[TB] FAIL stuffing_rd_req: got reads during null packet, required none");
        else passed++;
    endtask

    task automatic test_timeout_race();
        int k;
        bit ok;
        enter_reset();
        release_reset();
        repeat (IDLE_TIMEOUT - 2) @(posedge clk);
        #2;
        load_fifo(1, 8'h20, 8'h47);
        expect_pkt(1, 8'h20, 8'h47);
        for (k = IDLE_TIMEOUT - 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (d_valid) break;
        end
        checks++;
        if (k !== IDLE_TIMEOUT + 1 || null_out !== 1'b0)
            $display("[TB] FAIL race_start: got first valid at edge %0d null=%b, required %0d null=0",
                     k, null_out, IDLE_TIMEOUT + 1);
        else passed++;
        wait_drain(300, ok);
        checks++;
        if (!ok) $display("[TB] FAIL race_drain: got %0d bytes outstanding, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_sync_err();
        bit ok;
        enter_reset();
        load_fifo(1, 8'h55, 8'h46);
        expect_pkt(1, 8'h55, 8'h46);
        release_reset();
        wait_drain(600, ok);
        checks++;
        if (!ok) $display("[TB] FAIL sync_err_drain: got %0d bytes outstanding, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        enter_reset();
        load_fifo(0, 8'h30, 8'h47);
        load_fifo(1, 8'h60, 8'h47);
        expect_pkt(0, 8'h30, 8'h47);
        expect_pkt(1, 8'h60, 8'h47);
        release_reset();
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() <= 2*PKT_LEN - (HDR_BYTES + 101)) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) $display("[TB] FAIL reset_mid_reach: got %0d bytes outstanding, required byte 100 reached", exp_q.size());
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_out, d_valid, p_sync, null_out, sync_err, rd_req} !== '0)
            $display("[TB] FAIL reset_mid_outputs: got data=%h valid=%b psync=%b null=%b serr=%b rd=%b, required all 0",
                     data_out, d_valid, p_sync, null_out, sync_err, rd_req);
        else passed++;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < NUM_CH; i++) fifo[i].delete();
        load_fifo(0, 8'h11, 8'h47);
        load_fifo(1, 8'h22, 8'h47);
        expect_pkt(0, 8'h11, 8'h47);
        expect_pkt(1, 8'h22, 8'h47);
        release_reset();
        wait_drain(700, ok);
        checks++;
        if (!ok) $display("[TB] FAIL reset_mid_drain: got %0d bytes outstanding, required 0", exp_q.size());
        else passed++;
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < HDR_BYTES; i++)
                hdr_mem[c*HDR_BYTES + i] = 8'(8'h80 + 16*c + i);
        for (int i = 0; i < NUM_CH; i++) rd_count[i] = 0;
        test_reset();
        test_single();
        test_fairness();
        test_masking();
        test_stuffing();
        test_timeout_race();
        test_sync_err();
        test_reset_mid();
        enter_reset();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
